// File: rtl/cpu_step_controller.sv
// cpu_step_controller
//   Turns the divided clock, the front-panel step button and the mode switches
//   into a single-cycle CPU enable in the CLK domain. It also traps on a core
//   halt request and counts enabled cycles for the panel display.
//
// Ports
//   CLK         system clock; every state change happens on its rising edge
//   RST_N       asynchronous active-low reset
//   SLOW_CLK    divided clock (asynchronous); one step per rising edge in SLOW
//   STEP_BTN    raw, bouncing push-button (asynchronous, active-high)
//   MODE[1:0]   panel switches: 00 halt, 01 run, 10 slow, 11 single step
//   HALT_REQ    core executed HLT (synchronous to CLK)
//   CPU_EN      registered one-clock enable to the core
//   TRAPPED     registered; high while the controller sits in TRAP
//   STEP_COUNT  registered count of cycles with CPU_EN = 1 (wraps)
//   DBG_STATE   current FSM state, exposed for checkers
//
// There is no valid/ready handshake in this block. Every input is a level, and
// every output is a registered level updated on each CLK edge.
module cpu_step_controller #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int CNT_W           = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SLOW_CLK,
  input  logic             STEP_BTN,
  input  logic [1:0]       MODE,
  input  logic             HALT_REQ,
  output logic             CPU_EN,
  output logic             TRAPPED,
  output logic [CNT_W-1:0] STEP_COUNT,
  output logic [2:0]       DBG_STATE
);

  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_RUN  = 3'd1,
    S_SLOW = 3'd2,
    S_STEP = 3'd3,
    S_TRAP = 3'd4
  } state_t;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronizers, one chain per asynchronous input bit.
  logic       slow_s1, slow_s2, slow_prev;
  logic       btn_s1, btn_s2;
  logic [1:0] mode_s1, mode_s2;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slow_s1   <= 1'b0;
      slow_s2   <= 1'b0;
      slow_prev <= 1'b0;
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
      mode_s1   <= 2'b00;
      mode_s2   <= 2'b00;
    end else begin
      slow_s1   <= SLOW_CLK;
      slow_s2   <= slow_s1;
      slow_prev <= slow_s2;
      btn_s1    <= STEP_BTN;
      btn_s2    <= btn_s1;
      mode_s1   <= MODE;
      mode_s2   <= mode_s1;
    end
  end

  // High for exactly one CLK cycle per rising edge of the divided clock.
  logic slow_tick;
  assign slow_tick = slow_s2 & ~slow_prev;

  // Debouncer. The synced level must differ from the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles before it is accepted. A single
  // agreeing sample restarts the count.
  logic        btn_stable, btn_stable_d;
  logic [15:0] db_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      btn_stable   <= 1'b0;
      btn_stable_d <= 1'b0;
      db_cnt       <= 16'd0;
    end else begin
      btn_stable_d <= btn_stable;
      if (btn_s2 == btn_stable) begin
        db_cnt <= 16'd0;
      end else if (db_cnt == DB_LAST) begin
        btn_stable <= btn_s2;
        db_cnt     <= 16'd0;
      end else begin
        db_cnt <= db_cnt + 16'd1;
      end
    end
  end

  // Only presses make events; releases are ignored.
  logic press;
  assign press = btn_stable & ~btn_stable_d;

  state_t state, next_state;
  logic   en_next;

  always_comb begin
    next_state = state;
    if (state == S_TRAP) begin
      // Leaving a trap requires the operator to park the switches in halt.
      // HALT_REQ has no effect here.
      if (mode_s2 == 2'b00) next_state = S_HALT;
    end else if (HALT_REQ) begin
      next_state = S_TRAP;
    end else begin
      case (mode_s2)
        2'b00:   next_state = S_HALT;
        2'b01:   next_state = S_RUN;
        2'b10:   next_state = S_SLOW;
        default: next_state = S_STEP;
      endcase
    end
  end

  // Events that arrive outside their own mode are dropped, never queued.
  always_comb begin
    en_next = 1'b0;
    case (state)
      S_RUN:   en_next = 1'b1;
      S_SLOW:  en_next = slow_tick;
      S_STEP:  en_next = press;
      default: en_next = 1'b0;
    endcase
    if (HALT_REQ) en_next = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_HALT;
      CPU_EN  <= 1'b0;
      TRAPPED <= 1'b0;
    end else begin
      state   <= next_state;
      CPU_EN  <= en_next;
      TRAPPED <= (next_state == S_TRAP);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STEP_COUNT <= '0;
    end else if (CPU_EN) begin
      STEP_COUNT <= STEP_COUNT + CNT_W'(1);
    end
  end

  assign DBG_STATE = state;

endmodule

// File: tb/tb_cpu_step_controller.sv
module tb_cpu_step_controller;

  localparam int DEB    = 8;
  localparam int N_RAND = 3000;
  localparam int OFS    = 8;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        SLOW_CLK = 1'b0;
  logic        STEP_BTN = 1'b0;
  logic [1:0]  MODE = 2'b00;
  logic        HALT_REQ = 1'b0;
  logic        CPU_EN, TRAPPED, w_en, w_trapped;
  logic [15:0] STEP_COUNT;
  logic [3:0]  w_count;
  logic [2:0]  dbg_state, w_dbg_state;

  always #25 CLK = ~CLK;

  cpu_step_controller #(.DEBOUNCE_CYCLES(DEB), .CNT_W(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .SLOW_CLK(SLOW_CLK), .STEP_BTN(STEP_BTN),
    .MODE(MODE), .HALT_REQ(HALT_REQ), .CPU_EN(CPU_EN), .TRAPPED(TRAPPED),
    .STEP_COUNT(STEP_COUNT), .DBG_STATE(dbg_state)
  );

  // Narrow-counter copy sharing every input, used for the wrap checks.
  cpu_step_controller #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) u_wrap (
    .CLK(CLK), .RST_N(RST_N), .SLOW_CLK(SLOW_CLK), .STEP_BTN(STEP_BTN),
    .MODE(MODE), .HALT_REQ(HALT_REQ), .CPU_EN(w_en), .TRAPPED(w_trapped),
    .STEP_COUNT(w_count), .DBG_STATE(w_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [17:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset(input logic [1:0] mode, input logic btn);
    @(negedge CLK);
    RST_N    = 1'b0;
    MODE     = mode;
    STEP_BTN = btn;
    SLOW_CLK = 1'b0;
    HALT_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [1:0] mode;
    logic       halt;
    int         hold;
    logic       exp_en;
    logic       exp_trap;
  } vec_t;

  vec_t vecs[14];

  // ---------------- reference model storage ----------------
  // Index t+OFS holds the value seen at CLK edge t after reset release.
  // Entries at t <= 0 stay zero, which matches the all-zero reset state.
  int m_h  [0:N_RAND+OFS];
  int s_h  [0:N_RAND+OFS];
  int b_h  [0:N_RAND+OFS];
  int h_h  [0:N_RAND+OFS];
  int st_h [0:N_RAND+OFS];
  int stb_h[0:N_RAND+OFS];
  int en_h [0:N_RAND+OFS];
  int cnt_h[0:N_RAND+OFS];

  // Model state codes: 0..3 equal the mode value chosen; 4 is the trap.
  localparam int M_TRAP = 4;

  task automatic model_edge(input int t);
    int   i, prev, ms, en;
    logic flip;
    i    = t + OFS;
    prev = st_h[i-1];
    ms   = m_h[i-2];  // switch value that has crossed the synchronizer
    en   = 0;
    if (prev == 1) en = 1;
    if (prev == 2) en = (s_h[i-2] == 1 && s_h[i-3] == 0) ? 1 : 0;
    if (prev == 3) en = (stb_h[i-1] == 1 && stb_h[i-2] == 0) ? 1 : 0;
    if (h_h[i] == 1) en = 0;
    if (prev == M_TRAP) st_h[i] = (ms == 0) ? 0 : M_TRAP;
    else if (h_h[i] == 1) st_h[i] = M_TRAP;
    else st_h[i] = ms;
    // The accepted button level flips after DEB consecutive synced samples that
    // all disagree with it.
    flip = 1'b1;
    for (int j = 0; j < DEB; j++)
      if (b_h[i-2-j] == stb_h[i-1]) flip = 1'b0;
    stb_h[i] = flip ? 1 - stb_h[i-1] : stb_h[i-1];
    cnt_h[i] = (cnt_h[i-1] + en_h[i-1]) % 65536;
    en_h[i]  = en;
  endtask

  // ---------------- test ----------------
  initial begin
    int pulses, width_err, en_seen;
    int mode_left, slow_left, btn_left;
    logic [17:0] e;

    vecs[0]  = '{2'b00, 1'b0, 4, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 1'b0, 4, 1'b1, 1'b0};
    vecs[2]  = '{2'b01, 1'b1, 1, 1'b0, 1'b1};
    vecs[3]  = '{2'b01, 1'b0, 4, 1'b0, 1'b1};
    vecs[4]  = '{2'b11, 1'b0, 4, 1'b0, 1'b1};
    vecs[5]  = '{2'b00, 1'b0, 3, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 1'b0, 4, 1'b0, 1'b0};
    vecs[7]  = '{2'b01, 1'b0, 4, 1'b1, 1'b0};
    vecs[8]  = '{2'b00, 1'b0, 2, 1'b1, 1'b0};
    vecs[9]  = '{2'b00, 1'b0, 2, 1'b0, 1'b0};
    vecs[10] = '{2'b01, 1'b0, 4, 1'b1, 1'b0};
    vecs[11] = '{2'b00, 1'b1, 1, 1'b0, 1'b1};
    vecs[12] = '{2'b00, 1'b0, 1, 1'b0, 1'b1};
    vecs[13] = '{2'b00, 1'b0, 1, 1'b0, 1'b0};

    // --- reset hold and release with MODE = run ---
    @(negedge CLK);
    MODE = 2'b01;
    repeat (3) @(negedge CLK);
    check("rst_en", CPU_EN, 0);
    check("rst_count", STEP_COUNT, 0);
    check("rst_trapped", TRAPPED, 0);
    RST_N = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("rel_en_e%0d", k), CPU_EN, (k == 4) ? 1 : 0);
    end
    check("wrap_count_0", w_count, 0);
    for (int k = 1; k <= 100; k++) begin
      step();
      if (k <= 17) check($sformatf("wrap_count_%0d", k), w_count, k % 16);
    end
    check("run_count_100", STEP_COUNT, 100);

    // --- asynchronous reset between edges while enabled ---
    check("pre_async_en", CPU_EN, 1);
    @(posedge CLK);
    #5 RST_N = 1'b0;
    #1;
    check("async_en", CPU_EN, 0);
    check("async_count", STEP_COUNT, 0);
    check("async_trapped", TRAPPED, 0);
    check("async_wrap_count", w_count, 0);
    @(negedge CLK);
    RST_N = 1'b1;

    // --- table vectors: mode sequencing and trap priority ---
    do_reset(2'b00, 1'b0);
    foreach (vecs[v]) begin
      MODE     = vecs[v].mode;
      HALT_REQ = vecs[v].halt;
      repeat (vecs[v].hold) begin
        step();
        HALT_REQ = 1'b0;
      end
      check($sformatf("vec%0d_en", v), CPU_EN, vecs[v].exp_en);
      check($sformatf("vec%0d_trapped", v), TRAPPED, vecs[v].exp_trap);
    end

    // --- slow mode: 5 periods of 10 high / 10 low ---
    do_reset(2'b10, 1'b0);
    repeat (5) step();
    for (int p = 0; p < 5; p++) begin
      for (int c = 1; c <= 20; c++) begin
        SLOW_CLK = (c <= 10);
        step();
        check($sformatf("slow_p%0d_c%0d", p, c), CPU_EN, (c == 3) ? 1 : 0);
      end
    end
    SLOW_CLK = 1'b0;
    step();
    check("slow_count", STEP_COUNT, 5);

    // --- single step with a bouncing button ---
    do_reset(2'b11, 1'b0);
    repeat (5) step();
    pulses = 0;
    width_err = 0;
    for (int c = 0; c < 100; c++) begin
      if (c < 30) STEP_BTN = ((c / 3) % 2 == 0);
      else if (c < 70) STEP_BTN = 1'b1;
      else STEP_BTN = 1'b0;
      step();
      if (CPU_EN && !en_seen) pulses++;
      if (CPU_EN && en_seen) width_err++;
      en_seen = CPU_EN;
    end
    check("bounce_pulses", pulses, 1);
    check("bounce_width", width_err, 0);
    check("bounce_count", STEP_COUNT, 1);

    // --- button held through reset produces one press DEB cycles later ---
    do_reset(2'b11, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      step();
      check($sformatf("held_btn_e%0d", k), CPU_EN, (k == DEB + 3) ? 1 : 0);
    end
    STEP_BTN = 1'b0;

    // --- trap: ignore step presses, exit only through halt ---
    do_reset(2'b01, 1'b0);
    repeat (5) step();
    check("trap_pre_en", CPU_EN, 1);
    HALT_REQ = 1'b1;
    step();
    HALT_REQ = 1'b0;
    check("trap_en", CPU_EN, 0);
    check("trap_flag", TRAPPED, 1);
    MODE = 2'b11;
    en_seen = 0;
    for (int c = 0; c < 40; c++) begin
      STEP_BTN = (c < 20);
      step();
      if (CPU_EN) en_seen = 1;
    end
    check("trap_step_blocked", en_seen, 0);
    check("trap_still", TRAPPED, 1);
    MODE = 2'b00;
    step();
    step();
    check("trap_exit_e2", TRAPPED, 1);
    step();
    check("trap_exit_e3", TRAPPED, 0);

    // --- randomized run against the reference model ---
    do_reset(2'b00, 1'b0);
    mode_left = 0;
    slow_left = 3;
    btn_left  = 0;
    for (int t = 1; t <= N_RAND; t++) begin
      if (mode_left == 0) begin
        MODE      = 2'($urandom_range(0, 3));
        mode_left = $urandom_range(5, 60);
      end
      mode_left--;
      slow_left--;
      if (slow_left == 0) begin
        SLOW_CLK  = ~SLOW_CLK;
        slow_left = $urandom_range(3, 12);
      end
      if (btn_left == 0) begin
        STEP_BTN = ~STEP_BTN;
        btn_left = $urandom_range(1, 20);
      end
      btn_left--;
      HALT_REQ = ($urandom_range(0, 63) == 0);
      m_h[t+OFS] = MODE;
      s_h[t+OFS] = SLOW_CLK;
      b_h[t+OFS] = STEP_BTN;
      h_h[t+OFS] = HALT_REQ;
      step();
      model_edge(t);
      exp_q.push_back({en_h[t+OFS] == 1, st_h[t+OFS] == M_TRAP, 16'(cnt_h[t+OFS])});
      e = exp_q.pop_front();
      if (t % 3 == 0 || CPU_EN !== e[17])
        check($sformatf("rand_en_t%0d", t), CPU_EN, e[17]);
      if (t % 3 == 1 || TRAPPED !== e[16])
        check($sformatf("rand_trapped_t%0d", t), TRAPPED, e[16]);
      if (t % 3 == 2 || STEP_COUNT !== e[15:0])
        check($sformatf("rand_count_t%0d", t), STEP_COUNT, e[15:0]);
    end
    check("rand_final_count", STEP_COUNT, cnt_h[N_RAND+OFS]);
    check("rand_wrap_count", w_count, cnt_h[N_RAND+OFS] % 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
